mi_v_plic: RTL and testbench

MI_V_PLIC -- requirements
Module: mi_v_plic

---
 rtl/mi_v_plic_pkg.sv | 22 ++
 rtl/mi_v_plic_if.sv | 13 +
 rtl/mi_v_plic_gateway.sv | 40 ++++
 rtl/mi_v_plic.sv | 134 +++++++++++++
 tb/tb_mi_v_plic.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mi_v_plic_pkg.sv
// Shared constants for the mi_v_plic interrupt controller: register offsets,
// priority width and source-count limit.
package mi_v_plic_pkg;

  localparam int PRIO_W  = 3;
  localparam int MAX_SRC = 31;
  localparam int ID_W    = 5;

  localparam logic [21:0] OFF_PRIO_BASE = 22'h000000;
  localparam logic [21:0] OFF_PENDING   = 22'h001000;
  localparam logic [21:0] OFF_ENABLE    = 22'h002000;
  localparam logic [21:0] OFF_THRESHOLD = 22'h200000;
  localparam logic [21:0] OFF_CLAIM     = 22'h200004;

  localparam logic [PRIO_W-1:0] PRIO_RESET = 3'd1;

  // Byte offset of the priority register for source ID.
  function automatic logic [21:0] prio_offset(input int unsigned id);
    return OFF_PRIO_BASE + 22'(id << 2);
  endfunction

endpackage

// File: rtl/mi_v_plic_if.sv
// APB target bundle for mi_v_plic. A transfer is one setup cycle (psel=1,
// penable=0) then one access cycle (psel=1, penable=1); zero wait states, no pready.
interface mi_v_plic_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata);
endinterface

// File: rtl/mi_v_plic_gateway.sv
// Per-source gateway: tracks pending and in-flight; a new request is only
// accepted while the source is neither pending nor in-flight.
module mi_v_plic_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic src_irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic pending_q, pending_d;
  logic in_flight_q, in_flight_d;

  always_comb begin
    pending_d   = pending_q;
    in_flight_d = in_flight_q;
    if (claim) begin
      pending_d   = 1'b0;
      in_flight_d = 1'b1;
    end else begin
      // in_flight_q is the pre-complete value, so a held request re-pends one edge later
      if (src_irq && !pending_q && !in_flight_q) pending_d = 1'b1;
      if (complete) in_flight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/mi_v_plic.sv
// Single-target PLIC with an APB register port. Define MI_V_PLIC_PRIORITY_EN to
// implement per-source priority and a threshold; otherwise the lowest ID wins.
module mi_v_plic
  import mi_v_plic_pkg::*;
#(
  parameter int NUM_OF_INTS = 4
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NUM_OF_INTS-1:0] SRC_IRQ,
  input  logic [31:0]            TARGET_PADDR,
  input  logic                   TARGET_PSEL,
  input  logic                   TARGET_PENABLE,
  input  logic                   TARGET_PWRITE,
  input  logic [31:0]            TARGET_PWDATA,
  output logic [31:0]            TARGET_PRDATA,
  output logic                   PLIC_IRQ
);

  logic [21:0]                         addr;
  logic                                unused_paddr;
  logic                                wr_en, rd_sel, claim_ev, complete_ev;
  logic [NUM_OF_INTS:1]                pending;
  logic [NUM_OF_INTS:1]                enable_q, enable_d;
  logic [ID_W-1:0]                     claim_q, claim_d, max_id;
  logic                                irq_q, irq_d;
  logic [NUM_OF_INTS:1][PRIO_W-1:0]    prio_eff;
  logic [PRIO_W-1:0]                   thr_eff, best_prio;
  logic [31:0]                         prio_rdata, thr_rdata, rdata;

  assign addr         = TARGET_PADDR[21:0];
  assign unused_paddr = ^TARGET_PADDR[31:22];
  assign wr_en        = TARGET_PSEL & TARGET_PENABLE & TARGET_PWRITE;
  assign rd_sel       = TARGET_PSEL & ~TARGET_PWRITE;
  // Claim fires on the edge that ends the setup phase, so the access phase sees claim_q
  assign claim_ev     = rd_sel & ~TARGET_PENABLE & (addr == OFF_CLAIM);
  assign complete_ev  = wr_en & (addr == OFF_CLAIM);

`ifdef MI_V_PLIC_PRIORITY_EN
  logic [NUM_OF_INTS:1][PRIO_W-1:0] prio_q, prio_d;
  logic [PRIO_W-1:0]                thr_q, thr_d;

  always_comb begin
    prio_d = prio_q;
    thr_d  = thr_q;
    if (wr_en) begin
      if (addr == OFF_THRESHOLD) thr_d = TARGET_PWDATA[PRIO_W-1:0];
      for (int i = 1; i <= NUM_OF_INTS; i++) begin
        if (addr == prio_offset(i)) prio_d[i] = TARGET_PWDATA[PRIO_W-1:0];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prio_q <= {NUM_OF_INTS{PRIO_RESET}};
      thr_q  <= '0;
    end else begin
      prio_q <= prio_d;
      thr_q  <= thr_d;
    end
  end

  always_comb begin
    prio_rdata = '0;
    for (int i = 1; i <= NUM_OF_INTS; i++) begin
      if (addr == prio_offset(i)) prio_rdata = 32'(prio_q[i]);
    end
  end

  assign thr_rdata = (addr == OFF_THRESHOLD) ? 32'(thr_q) : '0;
  assign prio_eff  = prio_q;
  assign thr_eff   = thr_q;
`else
  assign prio_rdata = '0;
  assign thr_rdata  = '0;
  assign prio_eff   = {NUM_OF_INTS{PRIO_RESET}};
  assign thr_eff    = '0;
`endif

  for (genvar g = 1; g <= NUM_OF_INTS; g++) begin : g_gw
    mi_v_plic_gateway u_gw (
      .clk      (PCLK),
      .rst_n    (PRESETn),
      .src_irq  (SRC_IRQ[g-1]),
      .claim    (claim_ev && (max_id == ID_W'(g))),
      .complete (complete_ev && (TARGET_PWDATA == 32'(g))),
      .pending  (pending[g])
    );
  end

  // Ascending scan with strict '>' keeps the lowest ID on priority ties
  always_comb begin
    max_id    = '0;
    best_prio = '0;
    for (int i = 1; i <= NUM_OF_INTS; i++) begin
      if (pending[i] && enable_q[i] && (prio_eff[i] > thr_eff) && (prio_eff[i] > best_prio)) begin
        max_id    = ID_W'(i);
        best_prio = prio_eff[i];
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    claim_d  = claim_q;
    irq_d    = (max_id != '0);
    if (wr_en && (addr == OFF_ENABLE)) enable_d = TARGET_PWDATA[NUM_OF_INTS:1];
    if (claim_ev) claim_d = max_id;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      enable_q <= '0;
      claim_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      claim_q  <= claim_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = prio_rdata | thr_rdata;
    if (addr == OFF_PENDING)     rdata = 32'({pending, 1'b0});
    else if (addr == OFF_ENABLE) rdata = 32'({enable_q, 1'b0});
    else if (addr == OFF_CLAIM)  rdata = TARGET_PENABLE ? 32'(claim_q) : 32'(max_id);
  end

  assign TARGET_PRDATA = rd_sel ? rdata : '0;
  assign PLIC_IRQ      = irq_q;

endmodule

// File: tb/tb_mi_v_plic.sv
// Directed bench for mi_v_plic (NUM_OF_INTS=4): APB driver tasks push expected
// read data / irq levels into queues; a negedge monitor pops and compares.
module tb_mi_v_plic;
  import mi_v_plic_pkg::*;

`ifdef MI_V_PLIC_PRIORITY_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] src_irq;
  logic       plic_irq;
  logic       irq_chk;
  logic       done;

  mi_v_plic_if bus ();

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [0:0]  irq_exp_q[$];
  string       irq_name_q[$];

  int total;
  int bad;

  logic [31:0] exp_v;
  logic [0:0]  irq_v;
  string       nm_v;

  mi_v_plic #(.NUM_OF_INTS(4)) dut (
    .PCLK           (clk),
    .PRESETn        (rst_n),
    .SRC_IRQ        (src_irq),
    .TARGET_PADDR   (bus.paddr),
    .TARGET_PSEL    (bus.psel),
    .TARGET_PENABLE (bus.penable),
    .TARGET_PWRITE  (bus.pwrite),
    .TARGET_PWDATA  (bus.pwdata),
    .TARGET_PRDATA  (bus.prdata),
    .PLIC_IRQ       (plic_irq)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, queues exp=%0d irq=%0d", exp_q.size(), irq_exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic apb_write(input logic [21:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.paddr   = {10'b0, a};
    bus.pwdata  = d;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [21:0] a, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    bus.paddr   = {10'b0, a};
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] m);
    @(posedge clk); #1;
    src_irq = m;
    @(posedge clk); #1;
    src_irq = 4'b0;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    @(posedge clk); #1;
    irq_exp_q.push_back(e);
    irq_name_q.push_back(nm);
    irq_chk = 1'b1;
    @(negedge clk); #1;
    irq_chk = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.psel && bus.penable && !bus.pwrite) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: prdata=%h with no expected value queued", bus.prdata);
      end else begin
        exp_v = exp_q.pop_front();
        nm_v  = name_q.pop_front();
        if (bus.prdata !== exp_v) begin
          bad++;
          $display("FAIL %s: prdata=%h expected=%h", nm_v, bus.prdata, exp_v);
        end
      end
    end
    if (irq_chk) begin
      total++;
      if (irq_exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_irq_check: plic_irq=%b", plic_irq);
      end else begin
        irq_v = irq_exp_q.pop_front();
        nm_v  = irq_name_q.pop_front();
        if (plic_irq !== irq_v[0]) begin
          bad++;
          $display("FAIL %s: plic_irq=%b expected=%b", nm_v, plic_irq, irq_v[0]);
        end
      end
    end
    if (done) begin
      total++;
      if (exp_q.size() != 0 || irq_exp_q.size() != 0) begin
        bad++;
        $display("FAIL leftover: read_q=%0d irq_q=%0d expected 0 0", exp_q.size(), irq_exp_q.size());
      end
    end
  end

  // stimulus
  initial begin
    total       = 0;
    bad         = 0;
    done        = 1'b0;
    irq_chk     = 1'b0;
    rst_n       = 1'b0;
    src_irq     = 4'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset state
    chk_irq(1'b0, "rst_irq");
    apb_read(OFF_ENABLE, 32'h0, "rst_enable");
    apb_read(OFF_PENDING, 32'h0, "rst_pending");
    apb_read(OFF_CLAIM, 32'h0, "rst_claim_empty");
    apb_read(prio_offset(1), PRIO_EN ? 32'h1 : 32'h0, "rst_prio1");
    apb_read(OFF_THRESHOLD, 32'h0, "rst_threshold");

    // enable all; bit 0 and bits above 4 read back 0
    apb_write(OFF_ENABLE, 32'h0000_00FF);
    apb_read(OFF_ENABLE, 32'h0000_001E, "enable_rw");

    // single source ID2
    pulse_src(4'b0010);
    chk_irq(1'b1, "irq_rise_id2");
    apb_read(OFF_PENDING, 32'h4, "pending_id2");
    apb_read(OFF_CLAIM, 32'h2, "claim_id2");
    chk_irq(1'b0, "irq_fall_after_claim");

    // in-flight blocks a new request until complete
    pulse_src(4'b0010);
    apb_read(OFF_PENDING, 32'h0, "inflight_block");
    chk_irq(1'b0, "inflight_irq_low");
    apb_write(OFF_CLAIM, 32'h2);
    pulse_src(4'b0010);
    apb_read(OFF_PENDING, 32'h4, "repend_after_complete");
    apb_read(OFF_CLAIM, 32'h2, "claim_id2_again");
    apb_write(OFF_CLAIM, 32'h2);

    // two sources together: lowest ID first, or ID4 first with priority 3
    apb_write(prio_offset(4), 32'h3);
    apb_read(prio_offset(4), PRIO_EN ? 32'h3 : 32'h0, "prio4_rw");
    pulse_src(4'b1010);
    chk_irq(1'b1, "irq_two_src");
    apb_read(OFF_CLAIM, PRIO_EN ? 32'h4 : 32'h2, "claim_first");
    apb_read(OFF_CLAIM, PRIO_EN ? 32'h2 : 32'h4, "claim_second");
    chk_irq(1'b0, "irq_two_src_drained");
    apb_write(OFF_CLAIM, 32'h2);
    apb_write(OFF_CLAIM, 32'h4);

    // out-of-range and zero completes are ignored
    pulse_src(4'b0001);
    apb_read(OFF_CLAIM, 32'h1, "claim_id1");
    apb_write(OFF_CLAIM, 32'h5);
    apb_write(OFF_CLAIM, 32'h0);
    pulse_src(4'b0001);
    apb_read(OFF_PENDING, 32'h0, "bad_complete_ignored");
    apb_write(OFF_CLAIM, 32'h1);

    // held-high request re-pends after complete
    @(posedge clk); #1;
    src_irq = 4'b0100;
    apb_read(OFF_CLAIM, 32'h3, "claim_id3");
    apb_write(OFF_CLAIM, 32'h3);
    apb_read(OFF_PENDING, 32'h8, "level_repend");
    src_irq = 4'b0;
    apb_read(OFF_CLAIM, 32'h3, "claim_id3_again");
    apb_write(OFF_CLAIM, 32'h3);
    chk_irq(1'b0, "irq_idle");

    // disabled source stays pending but is not eligible
    apb_write(OFF_ENABLE, 32'h0);
    pulse_src(4'b0001);
    chk_irq(1'b0, "disabled_irq_low");
    apb_read(OFF_PENDING, 32'h2, "disabled_pending");
    apb_read(OFF_CLAIM, 32'h0, "claim_none");
    apb_read(OFF_PENDING, 32'h2, "claim_none_no_effect");
    apb_write(OFF_ENABLE, 32'h2);
    chk_irq(1'b1, "reenable_irq");

    // asynchronous reset in the middle of a claim setup phase
    @(posedge clk); #1;
    bus.paddr   = {10'b0, OFF_CLAIM};
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    #2 rst_n = 1'b0;
    irq_exp_q.push_back(1'b0);
    irq_name_q.push_back("async_reset_irq");
    irq_chk = 1'b1;
    @(negedge clk); #1;
    irq_chk  = 1'b0;
    bus.psel = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    apb_read(OFF_PENDING, 32'h0, "post_reset_pending");
    apb_read(OFF_ENABLE, 32'h0, "post_reset_enable");
    apb_read(OFF_CLAIM, 32'h0, "post_reset_claim");
    apb_read(prio_offset(4), PRIO_EN ? 32'h1 : 32'h0, "post_reset_prio4");
    chk_irq(1'b0, "post_reset_irq");

    // priority/threshold writes and unmapped space
    apb_write(prio_offset(1), 32'h7);
    apb_read(prio_offset(1), PRIO_EN ? 32'h7 : 32'h0, "prio1_write");
    apb_write(OFF_THRESHOLD, 32'h5);
    apb_read(OFF_THRESHOLD, PRIO_EN ? 32'h5 : 32'h0, "threshold_write");
    apb_write(22'h003000, 32'hFFFF_FFFF);
    apb_read(22'h003000, 32'h0, "unmapped_read");
    apb_read(OFF_ENABLE, 32'h0, "unmapped_write_ignored");

    @(posedge clk); #1;
    done = 1'b1;
    @(negedge clk); #1;
    done = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
